// File: rtl/dual_core_mailbox_pkg.sv
// Shared definitions for the dual-core mailbox: window base, register
// offsets, STATUS bit layout and a helper that packs the STATUS word.
package dual_core_mailbox_pkg;

  // Base of the mailbox window as seen by the top-level decoder and firmware.
  localparam logic [31:0] MBOX_BASE   = 32'h2000_0000;

  // Byte offsets of the per-side registers within the window.
  localparam logic [3:0]  MBOX_TX     = 4'h0;
  localparam logic [3:0]  MBOX_RX     = 4'h4;
  localparam logic [3:0]  MBOX_STATUS = 4'h8;
  localparam logic [3:0]  MBOX_RSVD   = 4'hC;

  // Register select decoded from address bits [3:2].
  typedef enum logic [1:0] {
    REG_TX     = MBOX_TX[3:2],
    REG_RX     = MBOX_RX[3:2],
    REG_STATUS = MBOX_STATUS[3:2],
    REG_RSVD   = MBOX_RSVD[3:2]
  } reg_sel_e;

  // STATUS bit positions and count field placement.
  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_OVERFLOW     = 2;
  localparam int ST_UNDERFLOW    = 3;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;
  localparam int ST_COUNT_W      = 8;

  function automatic reg_sel_e reg_sel(input logic [3:0] addr);
    return reg_sel_e'(addr[3:2]);
  endfunction

  function automatic logic [31:0] status_word(
    input logic                  rx_nonempty,
    input logic                  tx_full,
    input logic                  overflow,
    input logic                  underflow,
    input logic [ST_COUNT_W-1:0] rx_count,
    input logic [ST_COUNT_W-1:0] tx_count
  );
    logic [31:0] w;
    w                                   = '0;
    w[ST_RX_NONEMPTY]                   = rx_nonempty;
    w[ST_TX_FULL]                       = tx_full;
    w[ST_OVERFLOW]                      = overflow;
    w[ST_UNDERFLOW]                     = underflow;
    w[ST_RX_COUNT_LSB +: ST_COUNT_W]    = rx_count;
    w[ST_TX_COUNT_LSB +: ST_COUNT_W]    = tx_count;
    return w;
  endfunction

endpackage

// File: rtl/dual_core_mailbox_if.sv
// Native memory-bus slice for one core's mailbox window.
// The irq signal exists only when MAILBOX_IRQ_EN is defined.
interface dual_core_mailbox_if;
  logic        valid;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
`ifdef MAILBOX_IRQ_EN
  logic        irq;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata, irq);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata, irq);
`else
  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
`endif
endinterface

// File: rtl/dual_core_mailbox_fifo.sv
// 32-bit synchronous FIFO for one mailbox direction. Push to a full FIFO
// and pop from an empty FIFO are ignored; the caller flags them.
module dual_core_mailbox_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [31:0]            wdata,
  output logic [31:0]            head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; emptiness is tracked by count, so
  // clearing the pointers and count is enough and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dual_core_mailbox.sv
// Mailbox between two PicoRV32 cores: one FIFO per direction, a STATUS
// register per side, registered valid/ready response (1-cycle latency).
// Optional: define MAILBOX_IRQ_EN to add per-side rx_nonempty irq outputs.
module dual_core_mailbox
  import dual_core_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic                 clk,
  input logic                 resetn,
  dual_core_mailbox_if.slave  a,
  dual_core_mailbox_if.slave  b
);
  localparam int CW = $clog2(DEPTH) + 1;

  // served holds off re-acceptance until the core drops valid.
  logic          a_served, b_served;
  logic          a_accept, b_accept;
  logic          a_write, b_write;
  reg_sel_e      a_sel, b_sel;
  logic          ab_push, ab_pop, ba_push, ba_pop;
  logic [31:0]   ab_head, ba_head;
  logic [CW-1:0] ab_count, ba_count;
  logic          ab_full, ab_empty, ba_full, ba_empty;
  logic          a_ovf, a_unf, b_ovf, b_unf;
  logic [31:0]   a_status, b_status;
  logic [31:0]   a_rdata_next, b_rdata_next;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, a.addr[1:0], b.addr[1:0]};

  assign a_accept = a.valid && !a_served;
  assign b_accept = b.valid && !b_served;
  assign a_write  = |a.wstrb;
  assign b_write  = |b.wstrb;
  assign a_sel    = reg_sel(a.addr);
  assign b_sel    = reg_sel(b.addr);

  assign ab_push  = a_accept &&  a_write && (a_sel == REG_TX);
  assign ba_pop   = a_accept && !a_write && (a_sel == REG_RX);
  assign ba_push  = b_accept &&  b_write && (b_sel == REG_TX);
  assign ab_pop   = b_accept && !b_write && (b_sel == REG_RX);

  dual_core_mailbox_fifo #(.DEPTH(DEPTH)) u_fifo_ab (
    .clk(clk), .resetn(resetn), .push(ab_push), .pop(ab_pop), .wdata(a.wdata),
    .head(ab_head), .count(ab_count), .full(ab_full), .empty(ab_empty)
  );

  dual_core_mailbox_fifo #(.DEPTH(DEPTH)) u_fifo_ba (
    .clk(clk), .resetn(resetn), .push(ba_push), .pop(ba_pop), .wdata(b.wdata),
    .head(ba_head), .count(ba_count), .full(ba_full), .empty(ba_empty)
  );

  assign a_status = status_word(!ba_empty, ab_full, a_ovf, a_unf,
                                ST_COUNT_W'(ba_count), ST_COUNT_W'(ab_count));
  assign b_status = status_word(!ab_empty, ba_full, b_ovf, b_unf,
                                ST_COUNT_W'(ab_count), ST_COUNT_W'(ba_count));

  // Read data for the access being accepted; writes and empty pops read 0.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    a_rdata_next = '0;
    b_rdata_next = '0;
    if (!a_write) begin
      case (a_sel)
        REG_RX:     if (!ba_empty) a_rdata_next = ba_head;
        REG_STATUS: a_rdata_next = a_status;
        default:    a_rdata_next = '0;
      endcase
    end
    if (!b_write) begin
      case (b_sel)
        REG_RX:     if (!ab_empty) b_rdata_next = ab_head;
        REG_STATUS: b_rdata_next = b_status;
        default:    b_rdata_next = '0;
      endcase
    end
  end

  // Sticky error flags: set on dropped push / empty pop, cleared by STATUS write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_ovf <= 1'b0;
      a_unf <= 1'b0;
      b_ovf <= 1'b0;
      b_unf <= 1'b0;
    end else begin
      if (ab_push && ab_full) a_ovf <= 1'b0 | 1'b1;
      else if (a_accept && a_write && a_sel == REG_STATUS && a.wdata[ST_OVERFLOW]) a_ovf <= 1'b0;
      if (ba_pop && ba_empty) a_unf <= 1'b1;
      else if (a_accept && a_write && a_sel == REG_STATUS && a.wdata[ST_UNDERFLOW]) a_unf <= 1'b0;
      if (ba_push && ba_full) b_ovf <= 1'b1;
      else if (b_accept && b_write && b_sel == REG_STATUS && b.wdata[ST_OVERFLOW]) b_ovf <= 1'b0;
      if (ab_pop && ab_empty) b_unf <= 1'b1;
      else if (b_accept && b_write && b_sel == REG_STATUS && b.wdata[ST_UNDERFLOW]) b_unf <= 1'b0;
    end
  end

  // Bus responders: one-cycle ready pulse with registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a.ready  <= 1'b0;
      a.rdata  <= '0;
      a_served <= 1'b0;
      b.ready  <= 1'b0;
      b.rdata  <= '0;
      b_served <= 1'b0;
    end else begin
      a.ready  <= a_accept;
      b.ready  <= b_accept;
      if (a_accept) a.rdata <= a_rdata_next;
      if (b_accept) b.rdata <= b_rdata_next;
      a_served <= a_accept || (a_served && a.valid);
      b_served <= b_accept || (b_served && b.valid);
    end
  end

`ifdef MAILBOX_IRQ_EN
  // Level irq per side, following rx_nonempty one cycle after the FIFO update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a.irq <= 1'b0;
      b.irq <= 1'b0;
    end else begin
      a.irq <= !ba_empty;
      b.irq <= !ab_empty;
    end
  end
`endif
endmodule

// File: tb/tb_dual_core_mailbox.sv
// Directed bench for dual_core_mailbox (DEPTH=8): vector table plus
// hand-written handshake, reset and (with MAILBOX_IRQ_EN) irq sequences.
module tb_dual_core_mailbox;
  import dual_core_mailbox_pkg::*;

  typedef struct packed {
    logic        en;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    string       name;
    req_t        a;
    logic [31:0] exp_a;
    req_t        b;
    logic [31:0] exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dual_core_mailbox_if a_bus();
  dual_core_mailbox_if b_bus();

  dual_core_mailbox #(.DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .a(a_bus), .b(b_bus)
  );

  localparam req_t IDLE = '0;

  function automatic req_t rd(input logic [3:0] off);
    return '{en: 1'b1, addr: off, wdata: 32'h0, wstrb: 4'h0};
  endfunction

  function automatic req_t wrs(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    return '{en: 1'b1, addr: off, wdata: d, wstrb: s};
  endfunction

  function automatic req_t wr(input logic [3:0] off, input logic [31:0] d);
    return wrs(off, d, 4'hF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input req_t ra, input logic [31:0] ea,
                     input req_t rb, input logic [31:0] eb);
    vec_t v;
    v.name = n; v.a = ra; v.exp_a = ea; v.b = rb; v.exp_b = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input req_t ra, input req_t rb);
    a_bus.valid = ra.en; a_bus.addr = ra.addr; a_bus.wdata = ra.wdata; a_bus.wstrb = ra.wstrb;
    b_bus.valid = rb.en; b_bus.addr = rb.addr; b_bus.wdata = rb.wdata; b_bus.wstrb = rb.wstrb;
  endtask

  // One access per enabled side, bounded wait for ready.
  task automatic xfer(input req_t ra, input req_t rb, output logic [31:0] rda,
                      output logic [31:0] rdb, output logic ok);
    ok = 1'b0; rda = '0; rdb = '0;
    @(negedge clk);
    drive(ra, rb);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((!ra.en || a_bus.ready) && (!rb.en || b_bus.ready)) begin
        ok = 1'b1; rda = a_bus.rdata; rdb = b_bus.rdata;
        break;
      end
    end
    drive(IDLE, IDLE);
  endtask

  task automatic run(input string n, input req_t ra, input logic [31:0] ea,
                     input req_t rb, input logic [31:0] eb);
    logic [31:0] rda, rdb;
    logic ok;
    xfer(ra, rb, rda, rdb, ok);
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: no ready within 8 cycles", n);
    end else begin
      if (ra.en) check({n, "/a"}, rda, ea);
      if (rb.en) check({n, "/b"}, rdb, eb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    int          first;
    logic [31:0] full_addr;

    full_addr = MBOX_BASE | 32'(MBOX_STATUS);

    // Basic transfer A->B.
    add("a_push_11", wr(MBOX_TX, 32'h11), 32'h0, IDLE, 32'h0);
    add("a_push_22", wr(MBOX_TX, 32'h22), 32'h0, IDLE, 32'h0);
    add("a_push_33", wr(MBOX_TX, 32'h33), 32'h0, IDLE, 32'h0);
    add("b_stat_3",  IDLE, 32'h0, rd(full_addr[3:0]), 32'h0000_0301);
    add("a_stat_3",  rd(MBOX_STATUS), 32'h0003_0000, IDLE, 32'h0);
    add("b_pop_11",  IDLE, 32'h0, rd(MBOX_RX), 32'h11);
    add("b_pop_22",  IDLE, 32'h0, rd(MBOX_RX), 32'h22);
    add("b_pop_33",  IDLE, 32'h0, rd(MBOX_RX), 32'h33);
    add("b_stat_0",  IDLE, 32'h0, rd(MBOX_STATUS), 32'h0);
    add("a_stat_0",  rd(MBOX_STATUS), 32'h0, IDLE, 32'h0);
    // Overflow: nine pushes into an 8-deep FIFO.
    for (int k = 0; k < 9; k++) add($sformatf("a_fill_%0d", k), wr(MBOX_TX, 32'h100 + k), 32'h0, IDLE, 32'h0);
    add("a_stat_ovf", rd(MBOX_STATUS), 32'h0008_0006, IDLE, 32'h0);
    add("b_stat_8",   IDLE, 32'h0, rd(MBOX_STATUS), 32'h0000_0801);
    for (int k = 0; k < 8; k++) add($sformatf("b_drain_%0d", k), IDLE, 32'h0, rd(MBOX_RX), 32'h100 + k);
    add("b_pop_empty",  IDLE, 32'h0, rd(MBOX_RX), 32'h0);
    add("b_stat_unf",   IDLE, 32'h0, rd(MBOX_STATUS), 32'h0000_0008);
    add("a_stat_ovf2",  rd(MBOX_STATUS), 32'h0000_0004, IDLE, 32'h0);
    add("a_clr_ovf",    wr(MBOX_STATUS, 32'h4), 32'h0, IDLE, 32'h0);
    add("a_stat_clr",   rd(MBOX_STATUS), 32'h0, IDLE, 32'h0);
    add("b_clr_unf",    IDLE, 32'h0, wr(MBOX_STATUS, 32'h8), 32'h0);
    add("b_stat_clr",   IDLE, 32'h0, rd(MBOX_STATUS), 32'h0);
    // Same-edge push to full FIFO with pop from the other side.
    for (int k = 0; k < 8; k++) add($sformatf("a_fill2_%0d", k), wr(MBOX_TX, 32'h200 + k), 32'h0, IDLE, 32'h0);
    add("same_edge",    wr(MBOX_TX, 32'hAA), 32'h0, rd(MBOX_RX), 32'h200);
    add("a_stat_7",     rd(MBOX_STATUS), 32'h0007_0004, IDLE, 32'h0);
    add("b_stat_7",     IDLE, 32'h0, rd(MBOX_STATUS), 32'h0000_0701);
    for (int k = 1; k < 8; k++) add($sformatf("b_drain2_%0d", k), IDLE, 32'h0, rd(MBOX_RX), 32'h200 + k);
    add("aa_dropped",   IDLE, 32'h0, rd(MBOX_RX), 32'h0);
    // Same-edge pop from empty FIFO with push from the other side.
    add("pop_empty_push", wr(MBOX_TX, 32'hBB), 32'h0, rd(MBOX_RX), 32'h0);
    add("b_pop_bb",     IDLE, 32'h0, rd(MBOX_RX), 32'hBB);
    add("b_stat_unf2",  IDLE, 32'h0, rd(MBOX_STATUS), 32'h0000_0008);
    add("clr_both",     wr(MBOX_STATUS, 32'hC), 32'h0, wr(MBOX_STATUS, 32'hC), 32'h0);
    // B->A direction, partial strobe, ignored writes, reserved register.
    add("b_push_strb",  IDLE, 32'h0, wrs(MBOX_TX, 32'h1234_5678, 4'b0001), 32'h0);
    add("a_stat_rx1",   rd(MBOX_STATUS), 32'h0000_0101, IDLE, 32'h0);
    add("b_stat_tx1",   IDLE, 32'h0, rd(MBOX_STATUS), 32'h0001_0000);
    add("a_wr_rx_ign",  wr(MBOX_RX, 32'hDEAD), 32'h0, IDLE, 32'h0);
    add("a_rd_rsvd",    rd(MBOX_RSVD), 32'h0, rd(MBOX_TX), 32'h0);
    add("a_pop_b",      rd(MBOX_RX), 32'h1234_5678, IDLE, 32'h0);
    add("both_push",    wr(MBOX_TX, 32'hA1), 32'h0, wr(MBOX_TX, 32'hB1), 32'h0);
    add("both_pop",     rd(MBOX_RX), 32'hB1, rd(MBOX_RX), 32'hA1);
    add("a_stat_end",   rd(MBOX_STATUS), 32'h0, rd(MBOX_STATUS), 32'h0);

    // Reset state.
    drive(IDLE, IDLE);
    repeat (3) @(negedge clk);
    check("rst_a_ready", 32'(a_bus.ready), 32'h0);
    check("rst_b_ready", 32'(b_bus.ready), 32'h0);
    check("rst_a_rdata", a_bus.rdata, 32'h0);
    check("rst_b_rdata", b_bus.rdata, 32'h0);
`ifdef MAILBOX_IRQ_EN
    check("rst_a_irq", 32'(a_bus.irq), 32'h0);
    check("rst_b_irq", 32'(b_bus.irq), 32'h0);
`endif
    resetn = 1'b1;

    foreach (vecs[i]) run(vecs[i].name, vecs[i].a, vecs[i].exp_a, vecs[i].b, vecs[i].exp_b);

    // Valid held for 5 cycles: one ready pulse, one push.
    @(negedge clk);
    drive(wr(MBOX_TX, 32'h77), IDLE);
    pulses = 0; first = -1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (a_bus.ready) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    drive(IDLE, IDLE);
    check("hs_pulses", 32'(pulses), 32'd1);
    check("hs_latency", 32'(first), 32'd1);
    run("hs_b_stat", IDLE, 32'h0, rd(MBOX_STATUS), 32'h0000_0101);
    run("hs_b_pop",  IDLE, 32'h0, rd(MBOX_RX), 32'h77);
    run("hs_b_stat0", IDLE, 32'h0, rd(MBOX_STATUS), 32'h0);

`ifdef MAILBOX_IRQ_EN
    // irq follows rx_nonempty one cycle after the FIFO changes.
    @(negedge clk);
    drive(wr(MBOX_TX, 32'h5), IDLE);
    @(negedge clk);
    check("irq_push_ready", 32'(a_bus.ready), 32'h1);
    check("irq_b_pre", 32'(b_bus.irq), 32'h0);
    drive(IDLE, IDLE);
    @(negedge clk);
    check("irq_b_rise", 32'(b_bus.irq), 32'h1);
    check("irq_a_quiet", 32'(a_bus.irq), 32'h0);
    drive(IDLE, rd(MBOX_RX));
    @(negedge clk);
    check("irq_pop_ready", 32'(b_bus.ready), 32'h1);
    check("irq_pop_data", b_bus.rdata, 32'h5);
    check("irq_b_hold", 32'(b_bus.irq), 32'h1);
    drive(IDLE, IDLE);
    @(negedge clk);
    check("irq_b_fall", 32'(b_bus.irq), 32'h0);
`endif

    // Reset asserted mid-access with data in a FIFO.
    run("rst_pre_push", wr(MBOX_TX, 32'h66), 32'h0, IDLE, 32'h0);
    @(negedge clk);
    drive(rd(MBOX_STATUS), rd(MBOX_RX));
    #2 resetn = 1'b0;
    @(negedge clk);
    check("rstmid_a_ready", 32'(a_bus.ready), 32'h0);
    check("rstmid_b_ready", 32'(b_bus.ready), 32'h0);
`ifdef MAILBOX_IRQ_EN
    check("rstmid_b_irq", 32'(b_bus.irq), 32'h0);
`endif
    drive(IDLE, IDLE);
    resetn = 1'b1;
    run("rstmid_b_stat", IDLE, 32'h0, rd(MBOX_STATUS), 32'h0);
    run("rstmid_a_stat", rd(MBOX_STATUS), 32'h0, IDLE, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
